// File: rtl/seq101_pkg.sv
// Shared types and constants for the serial "101" detector.
// Holds the FSM state encoding, the matched pattern and the counter width default.
package seq101_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        S1   = 2'b01,
        S10  = 2'b10,
        DET  = 2'b11
    } state_t;

    // Bit 2 is the first bit received and bit 0 is the last.
    localparam logic [2:0] PATTERN = 3'b101;

    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/seq_101_sat_cnt.sv
// Saturating up-counter of detector matches.
// It holds at all-ones instead of wrapping, and R clears it asynchronously.
module seq_101_sat_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             R,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/seq_101_detector.sv
// Moore FSM that detects the serial pattern "101", with overlap selected by OVERLAP.
// Defining SEQ101_COUNT_EN adds det_count, a saturating count of matches.
module seq_101_detector
    import seq101_pkg::*;
#(
    parameter int OVERLAP = 1,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             R,
    input  logic             in,
`ifdef SEQ101_COUNT_EN
    output logic [CNT_W-1:0] det_count,
`endif
    output logic             out
);

    state_t r_state;
    state_t w_state_nxt;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // out depends only on r_state, so changes on `in` between edges never reach it.
    always_comb begin
        w_state_nxt = IDLE;
        out         = 1'b0;
        case (r_state)
            IDLE: w_state_nxt = (in == PATTERN[2]) ? S1  : IDLE;
            S1:   w_state_nxt = (in == PATTERN[1]) ? S10 : S1;
            S10:  w_state_nxt = (in == PATTERN[0]) ? DET : IDLE;
            DET: begin
                out = 1'b1;
                if (in) begin
                    w_state_nxt = S1;
                end else if (OVERLAP != 0) begin
                    w_state_nxt = S10;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef SEQ101_COUNT_EN
    logic w_cnt_inc;

    // The count updates on the same edge that enters DET, so it moves together with out.
    assign w_cnt_inc = (w_state_nxt == DET);

    seq_101_sat_cnt #(
        .CNT_W (CNT_W)
    ) u_sat_cnt (
        .clk     (clk),
        .R       (R),
        .i_inc   (w_cnt_inc),
        .o_count (det_count)
    );
`else
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_seq_101_detector.sv
// Directed bench for seq_101_detector with one OVERLAP=1 and one OVERLAP=0 instance.
// The OVERLAP=0 instance uses CNT_W=2, so the counter saturates when SEQ101_COUNT_EN is defined.
module tb_seq_101_detector;

    logic clk;
    logic R;
    logic in;
    logic out1;
    logic out0;
`ifdef SEQ101_COUNT_EN
    logic [7:0] cnt1;
    logic [1:0] cnt0;
`endif

    int errors;
    int checks;

    seq_101_detector #(
        .OVERLAP (1),
        .CNT_W   (8)
    ) dut_ov1 (
        .clk       (clk),
        .R         (R),
        .in        (in),
`ifdef SEQ101_COUNT_EN
        .det_count (cnt1),
`endif
        .out       (out1)
    );

    seq_101_detector #(
        .OVERLAP (0),
        .CNT_W   (2)
    ) dut_ov0 (
        .clk       (clk),
        .R         (R),
        .in        (in),
`ifdef SEQ101_COUNT_EN
        .det_count (cnt0),
`endif
        .out       (out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bench not finished");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        R  = 1'b1;
        in = 1'b0;
        @(negedge clk);
        R = 1'b0;
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        R = 1'b1;
        for (int t = 0; t < 15; t++) begin
            #1 in = ~in;
            checks++;
            if (out1 !== 1'b0 || out0 !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold t=%0d: out1=%b out0=%b expected 0", t, out1, out0);
            end
`ifdef SEQ101_COUNT_EN
            checks++;
            if (cnt1 !== 8'd0 || cnt0 !== 2'd0) begin
                errors++;
                $display("FAIL reset_hold_cnt t=%0d: cnt1=%0d cnt0=%0d expected 0", t, cnt1, cnt0);
            end
`endif
        end
        @(negedge clk);
        R  = 1'b0;
        in = 1'b0;
        // Reset while in DET must clear out before the next edge.
        step(1'b1);
        step(1'b0);
        step(1'b1);
        checks++;
        if (out1 !== 1'b1 || out0 !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_det: out1=%b out0=%b expected 1", out1, out0);
        end
        #2 R = 1'b1;
        #1;
        checks++;
        if (out1 !== 1'b0 || out0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: out1=%b out0=%b expected 0", out1, out0);
        end
`ifdef SEQ101_COUNT_EN
        checks++;
        if (cnt1 !== 8'd0 || cnt0 !== 2'd0) begin
            errors++;
            $display("FAIL reset_async_cnt: cnt1=%0d cnt0=%0d expected 0", cnt1, cnt0);
        end
`endif
        @(negedge clk);
        R  = 1'b0;
        in = 1'b0;
    endtask

    task automatic test_basic();
        logic s[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic e[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(s[i]);
            checks++;
            if (out1 !== e[i] || out0 !== e[i]) begin
                errors++;
                $display("FAIL basic bit%0d: out1=%b out0=%b expected %b", i + 1, out1, out0, e[i]);
            end
        end
`ifdef SEQ101_COUNT_EN
        checks++;
        if (cnt1 !== 8'd2 || cnt0 !== 2'd2) begin
            errors++;
            $display("FAIL basic_cnt: cnt1=%0d cnt0=%0d expected 2", cnt1, cnt0);
        end
`endif
    endtask

    task automatic test_overlap();
        logic s[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic e1[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic e0[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(s[i]);
            checks++;
            if (out1 !== e1[i]) begin
                errors++;
                $display("FAIL overlap1 bit%0d: out=%b expected %b", i + 1, out1, e1[i]);
            end
            checks++;
            if (out0 !== e0[i]) begin
                errors++;
                $display("FAIL overlap0 bit%0d: out=%b expected %b", i + 1, out0, e0[i]);
            end
        end
`ifdef SEQ101_COUNT_EN
        checks++;
        if (cnt1 !== 8'd2 || cnt0 !== 2'd1) begin
            errors++;
            $display("FAIL overlap_cnt: cnt1=%0d cnt0=%0d expected 2/1", cnt1, cnt0);
        end
`endif
    endtask

    task automatic test_no_false_hit();
        logic a[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
        logic b[3] = '{1'b0, 1'b0, 1'b0};
        logic c[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(a[i]);
            checks++;
            if (out1 !== 1'b0 || out0 !== 1'b0) begin
                errors++;
                $display("FAIL ones bit%0d: out1=%b out0=%b expected 0", i + 1, out1, out0);
            end
        end
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(b[i]);
            checks++;
            if (out1 !== 1'b0 || out0 !== 1'b0) begin
                errors++;
                $display("FAIL zeros bit%0d: out1=%b out0=%b expected 0", i + 1, out1, out0);
            end
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(c[i]);
            checks++;
            if (out1 !== 1'b0 || out0 !== 1'b0) begin
                errors++;
                $display("FAIL 1001 bit%0d: out1=%b out0=%b expected 0", i + 1, out1, out0);
            end
        end
    endtask

    task automatic test_saturation();
`ifdef SEQ101_COUNT_EN
        logic [1:0] ec[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`endif
        do_reset();
        for (int m = 0; m < 5; m++) begin
            step(1'b1);
            step(1'b0);
            step(1'b1);
            checks++;
            if (out1 !== 1'b1 || out0 !== 1'b1) begin
                errors++;
                $display("FAIL sat_pulse m%0d: out1=%b out0=%b expected 1", m + 1, out1, out0);
            end
`ifdef SEQ101_COUNT_EN
            checks++;
            if (cnt0 !== ec[m]) begin
                errors++;
                $display("FAIL sat_cnt0 m%0d: cnt=%0d expected %0d", m + 1, cnt0, ec[m]);
            end
            checks++;
            if (cnt1 !== 8'(m + 1)) begin
                errors++;
                $display("FAIL sat_cnt1 m%0d: cnt=%0d expected %0d", m + 1, cnt1, m + 1);
            end
`endif
            step(1'b0);
            step(1'b0);
        end
    endtask

    task automatic test_timing();
        logic s[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic e[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic snap;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(s[i]);
            checks++;
            if (out1 !== e[i]) begin
                errors++;
                $display("FAIL timing_edge bit%0d: out=%b expected %b", i + 1, out1, e[i]);
            end
            snap = e[i];
            for (int g = 0; g < 3; g++) begin
                #1 in = ~in;
                checks++;
                if (out1 !== snap) begin
                    errors++;
                    $display("FAIL timing_glitch bit%0d g%0d: out=%b expected %b", i + 1, g, out1, snap);
                end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        R      = 1'b1;
        in     = 1'b0;
        test_reset();
        test_basic();
        test_overlap();
        test_no_false_hit();
        test_saturation();
        test_timing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
